// File: rtl/cdc_toggle_tx.sv
// Source-domain half of a two-phase (toggle) CDC handshake.
// A word accepted on valid_i/ready_o is parked in data_q and announced by
// flipping req_q. Both stay frozen until the remote side flips async_ack_i
// to match, as seen through a STAGES-deep synchroniser.
module cdc_toggle_tx #(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  async_req_o,
  output logic [DATA_WIDTH-1:0] async_data_o,
  input  logic                  async_ack_i
);

  // A single flop cannot resolve metastability; refuse to build such a chain.
  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_toggle_tx: STAGES must be >= 2");
  end

  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]     ack_sync_q, ack_sync_d;
  logic                  ack_s;
  logic                  idle;
  logic                  accept;

  // Only the last synchroniser stage is safe to use in clk_i logic.
  assign ack_s  = ack_sync_q[STAGES-1];

  // Idle when the remote side has echoed the current request phase.
  assign idle   = (req_q == ack_s);
  assign accept = valid_i & idle;

  // Capture a new word and flip the request phase on acceptance; hold otherwise.
  always_comb begin
    // NOTE: every output of this block gets its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    req_d  = req_q;
    data_d = data_q;
    if (accept) begin
      req_d  = ~req_q;
      data_d = data_i;
    end
  end

  // Shift the raw acknowledge into the synchroniser; stage 0 is the only sampler.
  always_comb begin
    ack_sync_d = {ack_sync_q[STAGES-2:0], async_ack_i};
  end

  // State registers with asynchronous clear so the handshake restarts at phase 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the values from before the edge, including the sync chain.
    if (!rstn_i) begin
      req_q      <= 1'b0;
      data_q     <= '0;
      ack_sync_q <= '0;
    end else begin
      req_q      <= req_d;
      data_q     <= data_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // Cross-domain outputs come straight from flops: no glitches reach the far side.
  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign ready_o      = idle;

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// Self-checking bench for cdc_toggle_tx. Two instances (STAGES=2 and 4) share
// the same stimulus; a history-based model predicts both from the handshake
// rules: ready means "request phase equals the ack value seen STAGES edges ago".
module tb_cdc_toggle_tx;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          async_ack_i;

  logic          ready [2];
  logic          req   [2];
  logic [DW-1:0] dat   [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            stg [2] = '{2, 4};
  bit            m_req  [2];
  logic [DW-1:0] m_data [2];
  bit            hist [$];   // async_ack_i value present at each rising edge since reset

  always #5 clk_i = ~clk_i;

  cdc_toggle_tx #(.STAGES(2), .DATA_WIDTH(DW)) dut2 (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready[0]),
    .async_req_o (req[0]),
    .async_data_o(dat[0]),
    .async_ack_i (async_ack_i)
  );

  cdc_toggle_tx #(.STAGES(4), .DATA_WIDTH(DW)) dut4 (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready[1]),
    .async_req_o (req[1]),
    .async_data_o(dat[1]),
    .async_ack_i (async_ack_i)
  );

  function automatic bit ack_seen(int i);
    int m;
    m = hist.size();
    if (m >= stg[i]) return hist[m - stg[i]];
    return 1'b0;
  endfunction

  function automatic bit m_ready(int i);
    return m_req[i] == ack_seen(i);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_req[i]  = 1'b0;
      m_data[i] = '0;
    end
    hist.delete();
  endtask

  // Advance one clock: update the model at the rising edge, return at the falling edge.
  task automatic tick();
    bit acc [2];
    @(posedge clk_i);
    if (rstn_i === 1'b1) begin
      for (int i = 0; i < 2; i++) acc[i] = valid_i && m_ready(i);
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          m_req[i]  = ~m_req[i];
          m_data[i] = data_i;
        end
      end
      hist.push_back(async_ack_i);
    end
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    rstn_i      = 1'b0;
    valid_i     = 1'b0;
    async_ack_i = 1'b0;
    model_clear();
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i      = 1'b0;
    valid_i     = 1'b0;
    data_i      = '0;
    async_ack_i = 1'b0;
    model_clear();
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ready[i] !== 1'b1) begin
        failures++; $display("FAIL reset_ready dut%0d got=%b exp=1", i, ready[i]);
      end
      checks++;
      if (req[i] !== 1'b0) begin
        failures++; $display("FAIL reset_req dut%0d got=%b exp=0", i, req[i]);
      end
      checks++;
      if (dat[i] !== '0) begin
        failures++; $display("FAIL reset_data dut%0d got=%h exp=0", i, dat[i]);
      end
    end
    rstn_i = 1'b1;
  endtask

  // Single transfer on both instances, with a data change while busy.
  task automatic test_single_and_hold();
    bit exp_rdy2 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    valid_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) valid_i = 1'b0;
      if (e == 2) begin
        valid_i = 1'b1;
        data_i  = 32'h12345678;
      end
      if (e == 4) begin
        async_ack_i = 1'b1;
        valid_i     = 1'b0;
      end
      checks++;
      if (ready[0] !== exp_rdy2[e-1]) begin
        failures++; $display("FAIL single_ready edge%0d got=%b exp=%b", e, ready[0], exp_rdy2[e-1]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (req[i] !== 1'b1) begin
          failures++; $display("FAIL single_req dut%0d edge%0d got=%b exp=1", i, e, req[i]);
        end
        checks++;
        if (dat[i] !== 32'hDEADBEEF) begin
          failures++; $display("FAIL hold_data dut%0d edge%0d got=%h exp=deadbeef", i, e, dat[i]);
        end
      end
      checks++;
      if (ready[1] !== 1'b0) begin
        failures++; $display("FAIL single_busy4 edge%0d got=%b exp=0", e, ready[1]);
      end
    end
  endtask

  // Continues from the single transfer: ack captured at edge 5 reaches STAGES=4 at edge 8.
  task automatic test_stages4_latency();
    bit exp_rdy4 [2] = '{1'b0, 1'b1};
    for (int e = 7; e <= 8; e++) begin
      tick();
      checks++;
      if (ready[1] !== exp_rdy4[e-7]) begin
        failures++; $display("FAIL stages4_ready edge%0d got=%b exp=%b", e, ready[1], exp_rdy4[e-7]);
      end
      checks++;
      if (ready[0] !== 1'b1) begin
        failures++; $display("FAIL stages4_idle2 edge%0d got=%b exp=1", e, ready[0]);
      end
    end
  endtask

  // Ack flips while idle: ready drops after the sync delay and returns when ack flips back.
  task automatic test_spurious_ack();
    bit exp_rdy [2][6] = '{'{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                           '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}};
    valid_i     = 1'b0;
    async_ack_i = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 2) async_ack_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ready[i] !== exp_rdy[i][e-1]) begin
          failures++; $display("FAIL spurious_ready dut%0d edge%0d got=%b exp=%b", i, e, ready[i], exp_rdy[i][e-1]);
        end
        checks++;
        if (ready[i] !== m_ready(i)) begin
          failures++; $display("FAIL spurious_model dut%0d edge%0d got=%b exp=%b", i, e, ready[i], m_ready(i));
        end
      end
    end
  endtask

  // Four words back to back with the remote side echoing req three cycles later.
  task automatic test_back_to_back();
    int word;
    int cyc;
    bit will_acc;
    bit lb [$];
    pulse_reset();
    word    = 1;
    cyc     = 0;
    valid_i = 1'b1;
    data_i  = 32'd1;
    while (word <= 4 && cyc < 80) begin
      will_acc = m_ready(0);
      checks++;
      if (ready[0] !== will_acc) begin
        failures++; $display("FAIL b2b_ready cyc%0d got=%b exp=%b", cyc, ready[0], will_acc);
      end
      tick();
      cyc++;
      lb.push_back(req[0]);
      if (lb.size() > 3) async_ack_i = lb[lb.size()-4];
      if (will_acc) begin
        checks++;
        if (req[0] !== word[0]) begin
          failures++; $display("FAIL b2b_req word%0d got=%b exp=%b", word, req[0], word[0]);
        end
        checks++;
        if (dat[0] !== word) begin
          failures++; $display("FAIL b2b_data word%0d got=%0d exp=%0d", word, dat[0], word);
        end
        checks++;
        if (ready[0] !== 1'b0) begin
          failures++; $display("FAIL b2b_busy word%0d got=%b exp=0", word, ready[0]);
        end
        word++;
        data_i = word;
      end
      checks++;
      if (ready[1] !== m_ready(1) || req[1] !== m_req[1] || dat[1] !== m_data[1]) begin
        failures++;
        $display("FAIL b2b_model4 cyc%0d got=%b/%b/%h exp=%b/%b/%h", cyc,
                 ready[1], req[1], dat[1], m_ready(1), m_req[1], m_data[1]);
      end
    end
    valid_i = 1'b0;
    checks++;
    if (word <= 4) begin
      failures++; $display("FAIL b2b_timeout words_done=%0d exp=4", word - 1);
    end
  endtask

  // Random valid/data with a remote side that echoes req after a random delay.
  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 300; c++) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = $urandom;
      if ($urandom_range(0, 2) == 0) async_ack_i = req[0];
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ready[i] !== m_ready(i)) begin
          failures++; $display("FAIL rand_ready dut%0d cyc%0d got=%b exp=%b", i, c, ready[i], m_ready(i));
        end
        checks++;
        if (req[i] !== m_req[i]) begin
          failures++; $display("FAIL rand_req dut%0d cyc%0d got=%b exp=%b", i, c, req[i], m_req[i]);
        end
        checks++;
        if (dat[i] !== m_data[i]) begin
          failures++; $display("FAIL rand_data dut%0d cyc%0d got=%h exp=%h", i, c, dat[i], m_data[i]);
        end
      end
    end
    valid_i = 1'b0;
  endtask

  // Reset asserted between clock edges while busy must clear outputs at once.
  task automatic test_reset_mid_transfer();
    pulse_reset();
    valid_i = 1'b1;
    data_i  = 32'hA5A5_0F0F;
    tick();
    valid_i = 1'b0;
    checks++;
    if (req[0] !== 1'b1 || ready[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_busy got=%b/%b exp=1/0", req[0], ready[0]);
    end
    #2;
    rstn_i      = 1'b0;
    async_ack_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ready[i] !== 1'b1 || req[i] !== 1'b0 || dat[i] !== '0) begin
        failures++;
        $display("FAIL midrst_clear dut%0d got=%b/%b/%h exp=1/0/0", i, ready[i], req[i], dat[i]);
      end
    end
    model_clear();
    @(negedge clk_i);
    tick();
    rstn_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_and_hold();
    test_stages4_latency();
    test_spurious_ack();
    test_back_to_back();
    test_random();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_toggle_tx.md
Name: cdc_toggle_tx

Overview:
- Source-domain half of a two-phase (toggle) clock-domain-crossing handshake.
- Accepts a data word on a valid/ready interface in the clk_i domain and launches it across a clock boundary.
- Launch: toggles async_req_o and holds async_data_o stable until the remote receiver returns a matching toggle on async_ack_i.
- async_ack_i is re-synchronised internally by a STAGES-deep flop chain before use.

Parameters:
- STAGES, 2, depth of the internal ack synchroniser; legal range >= 2.
- DATA_WIDTH, 32, width of the transferred word; legal range >= 1.

Ports:
- clk_i  in  1  source-domain clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  source offers data_i.
- data_i  in  DATA_WIDTH  word to transfer.
- ready_o  out  1  block can accept a word this cycle.
- async_req_o  out  1  toggle request to remote domain.
- async_data_o  out  DATA_WIDTH  held data to remote domain.
- async_ack_i  in  1  toggle acknowledge from remote domain (asynchronous to clk_i).

Behaviour:
- State flops:
  - req_q (1 bit)
  - data_q (DATA_WIDTH)
  - ack_sync_q[STAGES-1:0], shift chain: stage0 samples async_ack_i; stage k samples stage k-1.
  - ack_s = ack_sync_q[STAGES-1].
- Reset (rstn_i low, asynchronous): req_q=0, data_q=0, ack_sync_q=0.
  - Outputs during and after reset: ready_o=1, async_req_o=0, async_data_o=0.
- Output drivers:
  - async_req_o=req_q; async_data_o=data_q; both driven directly from flops, no logic after them.
  - ready_o = (req_q == ack_s), decoded only from registers; idle when equal, busy when different.
- Accept: on a rising clk_i edge with valid_i=1 and ready_o=1:
  - data_q<=data_i
  - req_q<=~req_q
  - ready_o is 0 from the next cycle.
- valid_i=1 with ready_o=0: no state change. The source keeps valid_i and data_i asserted; the block does not enforce this.
- valid_i may drop without acceptance; no side effects.
- While busy, data_q and req_q are frozen (CDC stability requirement); no input can modify them.
- Completion timing:
  - async_ack_i toggles to equal req_q before clk_i edge N.
  - Stage0 captures the new value at edge N; ack_s updates at edge N+STAGES-1.
  - ready_o is 1 in the cycle after edge N+STAGES-1 (ack-to-ready latency STAGES edges, +1 when metastability resolves late).
- Back-to-back: a new word may be accepted in the first cycle ready_o=1. Round-trip per word = 1 (launch) + remote latency + STAGES cycles.
- Throughput: at most one outstanding word; no buffering.
- Spurious ack (async_ack_i toggles while idle):
  - ack_s != req_q, so ready_o falls and stays 0 until the ack toggles back.
  - Treated as a protocol violation; the only guaranteed recovery is reset.
- Reset mid-transfer: all flops clear immediately; any in-flight word is lost. The remote receiver must be reset concurrently so its ack returns to 0.
- async_ack_i is used only through stage0 of the chain; no other logic samples it.

Test Plan:
- Reset: hold rstn_i=0 for 3 cycles with async_ack_i=0 -> ready_o=1, async_req_o=0, async_data_o=0.
- Single transfer, STAGES=2:
  - Stimulus: valid_i=1, data_i=32'hDEADBEEF at edge 1; bench toggles async_ack_i to 1 before edge 5.
  - Required: async_req_o=1 and async_data_o=32'hDEADBEEF from edge 1; ready_o=0 during cycles 2-5; ready_o=1 after edge 6.
- Hold while busy: change data_i to 32'h12345678 with valid_i=1 while busy -> async_data_o stays 32'hDEADBEEF and async_req_o stays 1.
- Back-to-back with 3-cycle loopback ack, 4 words (1,2,3,4):
  - async_req_o toggles 0->1->0->1->0.
  - async_data_o sequence is 1,2,3,4.
  - Each word is accepted in the first cycle ready_o=1.
- STAGES=4: ack toggles before edge N -> ready_o returns to 1 in the cycle after edge N+3.
- Reset mid-transfer: assert rstn_i while busy (req_q=1) -> async_req_o=0, async_data_o=0, ready_o=1 immediately (asynchronously), with async_ack_i forced to 0.
